// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: board-side SPI pins, mode selects, the transmit
// handshake and the receive/status outputs. The slave modport is the
// design's view; the master modport is the view of whatever drives it.
interface spi_slave_if #(
  parameter int DATA_W = 8
);
  localparam int CNT_W = $clog2(DATA_W);

  logic              cpol;
  logic              cpha;
  logic              spi_clk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_underrun;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              busy;
  logic [CNT_W-1:0]  bit_cnt;

  modport slave (
    input  cpol, cpha, spi_clk, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, tx_underrun, rx_data, rx_valid,
           frame_err, busy, bit_cnt
  );

  modport master (
    output cpol, cpha, spi_clk, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, tx_underrun, rx_data, rx_valid,
           frame_err, busy, bit_cnt
  );
endinterface

// File: rtl/spi_slave.sv
// Oversampled SPI slave, all four CPOL/CPHA modes, MSB-first words in both
// directions. Pins are synchronized into clk; a single-entry buffer feeds
// the transmit shift register, received words appear with a 1-clk strobe.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  spi_slave_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sclk_prev;
  logic sclk_s, cs_n_s, mosi_s;

  logic cpol_q, cpha_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_data_q;
  logic rx_valid_q, frame_err_q, tx_underrun_q;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] buf_data;
  logic buf_full;

  logic sclk_change, leading_edge, trailing_edge, sample_edge;
  logic start_frame, end_frame, abort_err, sample_en, word_done, load_tx;
  logic tx_accept;
  logic miso_c, miso_oe_c, busy_c;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_n_s = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edges are classified against the idle level latched at frame start.
  assign sclk_change   = sclk_s ^ sclk_prev;
  assign leading_edge  = sclk_change & (sclk_s != cpol_q);
  assign trailing_edge = sclk_change & (sclk_s == cpol_q);
  assign sample_edge   = cpha_q ? trailing_edge : leading_edge;

  assign tx_accept = bus.tx_valid & ~buf_full;

  // Pin synchronizers, reset to the deselected/idle pin levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '1;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev <= sclk_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Frame sequencing: chip select wins over a coincident sample edge.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    abort_err   = 1'b0;
    sample_en   = 1'b0;
    word_done   = 1'b0;
    load_tx     = 1'b0;
    miso_c      = 1'b1;
    miso_oe_c   = 1'b0;
    busy_c      = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_n_s) begin
          state_next  = SHIFT;
          start_frame = 1'b1;
          load_tx     = 1'b1;
        end
      end
      SHIFT: begin
        miso_c    = tx_shift[DATA_W-1];
        miso_oe_c = 1'b1;
        busy_c    = 1'b1;
        if (cs_n_s) begin
          state_next = IDLE;
          end_frame  = 1'b1;
          abort_err  = (bit_cnt_q != '0);
        end else if (sample_edge) begin
          sample_en = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            word_done = 1'b1;
            load_tx   = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Receive path: mode latch, bit counter, shift register and word strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= abort_err;
      if (start_frame) begin
        cpol_q <= bus.cpol;
        cpha_q <= bus.cpha;
      end
      if (start_frame || end_frame) begin
        bit_cnt_q <= '0;
      end else if (sample_en) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
        if (word_done) begin
          rx_data_q  <= {rx_shift[DATA_W-2:0], mosi_s};
          rx_valid_q <= 1'b1;
          bit_cnt_q  <= '0;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
    end
  end

  // Transmit path: buffer handshake, shift register loads and underrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift      <= '1;
      tx_underrun_q <= 1'b0;
      buf_full      <= 1'b0;
      buf_data      <= '0;
    end else begin
      tx_underrun_q <= 1'b0;
      if (load_tx) begin
        if (buf_full) begin
          tx_shift <= buf_data;
        end else begin
          tx_shift      <= '1;
          tx_underrun_q <= 1'b1;
        end
      end else if (sample_en) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
      if (tx_accept) begin
        buf_full <= 1'b1;
        buf_data <= bus.tx_data;
      end else if (load_tx) begin
        buf_full <= 1'b0;
      end
    end
  end

  assign bus.miso        = miso_c;
  assign bus.miso_oe     = miso_oe_c;
  assign bus.busy        = busy_c;
  assign bus.tx_ready    = ~buf_full;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.bit_cnt     = bit_cnt_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged SPI master at clk/4, a vector table
// covering the four modes, and hand-written sequences for back-to-back
// words, underrun, aborted frames and reset mid-frame.
module tb_spi_slave;
  localparam int H = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  int   fe_cnt;
  int   ur_cnt;
  int   rx_cnt;
  logic rv_d, fe_d, ur_d;
  logic m_cpol, m_cpha;
  logic [7:0] got, g1, g2;
  logic [7:0] exp_q[$];
  int   rx_cycle_q[$];

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] mosi_w;
    logic [7:0] tx_w;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[5];

  spi_slave_if #(.DATA_W(8)) bus ();

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running system clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every received word is popped against the expected
  // queue, and each strobe is checked to be exactly one clk wide.
  always @(negedge clk) begin
    if (reset) begin
      rv_d <= 1'b0;
      fe_d <= 1'b0;
      ur_d <= 1'b0;
    end else begin
      if (bus.rx_valid) begin
        rx_cnt++;
        rx_cycle_q.push_back(cyc);
        check_output("rx_valid_width", {31'd0, rv_d}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rx_unexpected: got 0x%0h expected no word", bus.rx_data);
        end else begin
          check_output("rx_word", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (bus.frame_err) begin
        fe_cnt++;
        check_output("frame_err_width", {31'd0, fe_d}, 32'd0);
      end
      if (bus.tx_underrun) begin
        ur_cnt++;
        check_output("underrun_width", {31'd0, ur_d}, 32'd0);
      end
      rv_d <= bus.rx_valid;
      fe_d <= bus.frame_err;
      ur_d <= bus.tx_underrun;
    end
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] w);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic set_mode(input logic p, input logic h);
    m_cpol      = p;
    m_cpha      = h;
    bus.cpol    = p;
    bus.cpha    = h;
    bus.spi_clk = p;
    wait_clk(6);
  endtask

  task automatic select_slave();
    bus.cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic end_frame();
    wait_clk(4);
    bus.cs_n = 1'b1;
    wait_clk(6);
  endtask

  // Master bit engine: drives MOSI on the non-sampling edge and captures
  // MISO at the sampling edge, MSB first.
  task automatic spi_bits(input logic [7:0] w, input int nbits,
                          output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      if (!m_cpha) begin
        bus.mosi = w[7-i];
        wait_clk(H);
        bus.spi_clk = ~m_cpol;
        rx = {rx[6:0], bus.miso};
        wait_clk(H);
        bus.spi_clk = m_cpol;
      end else begin
        bus.spi_clk = ~m_cpol;
        bus.mosi = w[7-i];
        wait_clk(H);
        bus.spi_clk = m_cpol;
        rx = {rx[6:0], bus.miso};
        wait_clk(H);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_miso"},     {31'd0, bus.miso},        32'd1);
    check_output({tag, "_miso_oe"},  {31'd0, bus.miso_oe},     32'd0);
    check_output({tag, "_tx_ready"}, {31'd0, bus.tx_ready},    32'd1);
    check_output({tag, "_rx_data"},  {24'd0, bus.rx_data},     32'd0);
    check_output({tag, "_rx_valid"}, {31'd0, bus.rx_valid},    32'd0);
    check_output({tag, "_underrun"}, {31'd0, bus.tx_underrun}, 32'd0);
    check_output({tag, "_frame_err"},{31'd0, bus.frame_err},   32'd0);
    check_output({tag, "_busy"},     {31'd0, bus.busy},        32'd0);
    check_output({tag, "_bit_cnt"},  {29'd0, bus.bit_cnt},     32'd0);
  endtask

  initial begin
    int n0, ur0, fe0, rx0, diff;
    vecs[0] = '{1'b0, 1'b0, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
    vecs[1] = '{1'b0, 1'b0, 8'h96, 8'h5A, 8'h96, 8'h5A};
    vecs[2] = '{1'b0, 1'b1, 8'h96, 8'h5A, 8'h96, 8'h5A};
    vecs[3] = '{1'b1, 1'b0, 8'h96, 8'h5A, 8'h96, 8'h5A};
    vecs[4] = '{1'b1, 1'b1, 8'h96, 8'h5A, 8'h96, 8'h5A};

    checks = 0; failures = 0; cyc = 0;
    fe_cnt = 0; ur_cnt = 0; rx_cnt = 0;
    m_cpol = 1'b0; m_cpha = 1'b0;
    reset = 1'b1;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.spi_clk = 1'b0;
    bus.cs_n = 1'b1; bus.mosi = 1'b1;
    bus.tx_data = 8'd0; bus.tx_valid = 1'b0;
    wait_clk(4);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_clk(4);

    $display("[TB] vector table");
    for (int i = 0; i < 5; i++) begin
      set_mode(vecs[i].cpol, vecs[i].cpha);
      check_output("idle_miso",    {31'd0, bus.miso},    32'd1);
      check_output("idle_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
      write_tx(vecs[i].tx_w);
      check_output("buf_full_ready", {31'd0, bus.tx_ready}, 32'd0);
      exp_q.push_back(vecs[i].exp_rx);
      select_slave();
      check_output("sel_busy",     {31'd0, bus.busy},     32'd1);
      check_output("sel_miso_oe",  {31'd0, bus.miso_oe},  32'd1);
      check_output("sel_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
      spi_bits(vecs[i].mosi_w, 8, got);
      end_frame();
      check_output("master_rx", {24'd0, got}, {24'd0, vecs[i].exp_miso});
      check_output("rx_data_hold", {24'd0, bus.rx_data}, {24'd0, vecs[i].exp_rx});
      check_output("post_miso",    {31'd0, bus.miso},    32'd1);
      check_output("post_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
      check_output("post_busy",    {31'd0, bus.busy},    32'd0);
    end

    $display("[TB] back-to-back words");
    write_tx(8'h24);
    set_mode(1'b0, 1'b0);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    n0 = rx_cycle_q.size();
    select_slave();
    fork
      begin
        wait_clk(8);
        write_tx(8'hC3);
      end
      spi_bits(8'h01, 8, g1);
    join
    spi_bits(8'h80, 8, g2);
    end_frame();
    check_output("b2b_word1_miso", {24'd0, g1}, 32'h24);
    check_output("b2b_word2_miso", {24'd0, g2}, 32'hC3);
    check_output("b2b_rx_count", rx_cycle_q.size(), n0 + 2);
    diff = (rx_cycle_q.size() >= n0 + 2) ? rx_cycle_q[n0+1] - rx_cycle_q[n0] : -1;
    check_output("b2b_spacing", diff, 32);

    $display("[TB] underrun at frame start");
    ur0 = ur_cnt;
    set_mode(1'b0, 1'b0);
    exp_q.push_back(8'h69);
    select_slave();
    check_output("underrun_once", ur_cnt, ur0 + 1);
    spi_bits(8'h69, 8, got);
    end_frame();
    check_output("underrun_miso", {24'd0, got}, 32'hFF);
    check_output("underrun_rx",   {24'd0, bus.rx_data}, 32'h69);

    $display("[TB] aborted frame");
    fe0 = fe_cnt;
    rx0 = rx_cnt;
    set_mode(1'b0, 1'b0);
    select_slave();
    spi_bits(8'hF0, 5, got);
    wait_clk(2);
    check_output("partial_bit_cnt", {29'd0, bus.bit_cnt}, 32'd5);
    end_frame();
    check_output("frame_err_count", fe_cnt, fe0 + 1);
    check_output("abort_no_rx",     rx_cnt, rx0);
    check_output("abort_rx_keep",   {24'd0, bus.rx_data}, 32'h69);
    check_output("abort_bit_cnt",   {29'd0, bus.bit_cnt}, 32'd0);
    exp_q.push_back(8'h7E);
    select_slave();
    spi_bits(8'h7E, 8, got);
    end_frame();
    check_output("after_abort_rx", {24'd0, bus.rx_data}, 32'h7E);

    $display("[TB] reset mid-frame");
    fe0 = fe_cnt;
    rx0 = rx_cnt;
    write_tx(8'h99);
    set_mode(1'b0, 1'b0);
    select_slave();
    write_tx(8'h33);
    spi_bits(8'hAA, 4, got);
    reset = 1'b1;
    bus.cs_n = 1'b1;
    bus.spi_clk = 1'b0;
    bus.mosi = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    wait_clk(2);
    reset = 1'b0;
    wait_clk(6);
    check_output("reset_no_frame_err", fe_cnt, fe0);
    check_output("reset_no_rx",        rx_cnt, rx0);
    exp_q.push_back(8'h42);
    set_mode(1'b0, 1'b0);
    select_slave();
    spi_bits(8'h42, 8, got);
    end_frame();
    check_output("post_reset_rx",   {24'd0, bus.rx_data}, 32'h42);
    check_output("post_reset_miso", {24'd0, got}, 32'hFF);

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
